// File: rtl/vga_bars.sv
// Multi-bar VGA renderer on an Avalon-MM slave: NUM_BARS vertical bars over a background,
// with bar registers double-buffered and committed at the start of vertical blanking.
module vga_bars #(
  parameter int unsigned NUM_BARS     = 4,
  parameter int unsigned BAR_HALF_W   = 8,
  parameter int unsigned MID_Y        = 239,
  parameter int unsigned HACTIVE      = 1280,
  parameter int unsigned HFRONT_PORCH = 32,
  parameter int unsigned HSYNC        = 192,
  parameter int unsigned HBACK_PORCH  = 96,
  parameter int unsigned VACTIVE      = 480,
  parameter int unsigned VFRONT_PORCH = 10,
  parameter int unsigned VSYNC        = 2,
  parameter int unsigned VBACK_PORCH  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  localparam int unsigned HTOTAL = HACTIVE + HFRONT_PORCH + HSYNC + HBACK_PORCH;
  localparam int unsigned VTOTAL = VACTIVE + VFRONT_PORCH + VSYNC + VBACK_PORCH;

  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(HACTIVE);
  localparam logic [10:0] HS_BEG = 11'(HACTIVE + HFRONT_PORCH);
  localparam logic [10:0] HS_END = 11'(HACTIVE + HFRONT_PORCH + HSYNC);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(VACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(VACTIVE + VFRONT_PORCH);
  localparam logic [9:0]  VS_END = 10'(VACTIVE + VFRONT_PORCH + VSYNC);
  localparam logic [9:0]  V_MID  = 10'(MID_Y);
  localparam logic signed [11:0] HALF_W = 12'(BAR_HALF_W);
  localparam logic [13:0] BAR_CNT = 14'(NUM_BARS);

  logic [10:0] hcount;
  logic [9:0]  vcount;

  logic [23:0] bg;
  logic        enable;
  logic        pending;
  logic [15:0] frame_count;

  logic [10:0] sh_x [NUM_BARS];
  logic [9:0]  sh_y [NUM_BARS];
  logic [23:0] sh_c [NUM_BARS];
  logic [10:0] ac_x [NUM_BARS];
  logic [9:0]  ac_y [NUM_BARS];
  logic [23:0] ac_c [NUM_BARS];

  logic        wr_en;
  logic        rd_en;
  logic        commit;
  logic        bar_wr;
  logic [15:0] bar_off;
  logic [13:0] bar_idx;
  logic [1:0]  bar_fld;

  logic        unused_wd;

  assign unused_wd  = ^writedata[31:24];
  assign VGA_SYNC_n = 1'b0;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign bar_off = address - 16'd8;
  assign bar_idx = bar_off[15:2];
  assign bar_fld = bar_off[1:0];
  assign bar_wr  = wr_en && (address >= 16'd8) && (bar_idx < BAR_CNT) && (bar_fld != 2'd3);
  assign commit  = (hcount == 11'd0) && (vcount == V_ACT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg          <= {8'd10, 8'd20, 8'd30};
      enable      <= 1'b1;
      pending     <= 1'b0;
      frame_count <= '0;
      readdata    <= '0;
    end else begin
      if (wr_en && address == 16'd0) bg <= writedata[23:0];
      if (wr_en && address == 16'd1) enable <= writedata[0];
      // A bar write coinciding with the commit keeps the new value pending
      if (bar_wr)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
      if (commit) frame_count <= frame_count + 16'd1;
      if (rd_en)
        readdata <= (address == 16'd2) ? {pending, 15'd0, frame_count} : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        sh_x[i] <= 11'(((64 + 128 * i) % 640) * 2);
        sh_y[i] <= V_MID;
        sh_c[i] <= 24'h800080;
        ac_x[i] <= 11'(((64 + 128 * i) % 640) * 2);
        ac_y[i] <= V_MID;
        ac_c[i] <= 24'h800080;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        if (commit) begin
          ac_x[i] <= sh_x[i];
          ac_y[i] <= sh_y[i];
          ac_c[i] <= sh_c[i];
        end
        if (bar_wr && bar_idx == 14'(i)) begin
          case (bar_fld)
            2'd0:    sh_x[i] <= {writedata[9:0], 1'b0};
            2'd1:    sh_y[i] <= writedata[9:0];
            default: sh_c[i] <= writedata[23:0];
          endcase
        end
      end
    end
  end

  logic [NUM_BARS-1:0] hit;
  logic signed [11:0]  dx;
  logic                col_hit;
  logic                row_hit;

  // Column test done as |hcount - xa| < half-width so no intermediate can overflow 12 bits
  always_comb begin
    hit     = '0;
    dx      = '0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      dx      = $signed({1'b0, hcount}) - $signed({1'b0, ac_x[i]});
      col_hit = (dx > -HALF_W) && (dx < HALF_W);
      if (ac_y[i] < V_MID)
        row_hit = (vcount >= ac_y[i]) && (vcount <= V_MID);
      else if (ac_y[i] > V_MID)
        row_hit = (vcount >= V_MID) && (vcount <= ac_y[i]);
      else
        row_hit = (vcount == V_MID);
      hit[i] = col_hit && row_hit;
    end
  end

  logic hs_c;
  logic vs_c;
  logic de_c;

  assign hs_c = !((hcount >= HS_BEG) && (hcount < HS_END));
  assign vs_c = !((vcount >= VS_BEG) && (vcount < VS_END));
  assign de_c = (hcount < H_ACT) && (vcount < V_ACT);

  logic [NUM_BARS-1:0] hit_q;
  logic [23:0]         bg_q;
  logic                hs_q;
  logic                vs_q;
  logic                de_q;
  logic                ck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= '0;
      bg_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      ck_q  <= 1'b0;
    end else begin
      hit_q <= enable ? hit : '0;
      bg_q  <= bg;
      hs_q  <= hs_c;
      vs_q  <= vs_c;
      de_q  <= de_c;
      ck_q  <= hcount[0];
    end
  end

  logic [23:0] pix;
  logic        found;

  always_comb begin
    pix   = bg_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      if (hit_q[i] && !found) begin
        pix   = ac_c[i];
        found = 1'b1;
      end
    end
    if (!de_q) pix = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      VGA_R       <= pix[23:16];
      VGA_G       <= pix[15:8];
      VGA_B       <= pix[7:0];
      VGA_HS      <= hs_q;
      VGA_VS      <= vs_q;
      VGA_BLANK_n <= de_q;
      VGA_CLK     <= ck_q;
    end
  end

endmodule

// File: tb/tb_vga_bars.sv
// Scoreboard bench for vga_bars on a shrunken raster: a frame-level reference model predicts
// every output cycle and every read, and a separate monitor compares what the DUT presents.
module tb_vga_bars;

  localparam int HA = 160, HF = 4, HSY = 12, HB = 4;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VA = 12, VF = 1, VSY = 2, VB = 1;
  localparam int VT = VA + VF + VSY + VB;
  localparam int NB = 4, HW = 8, MID = 6;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  vga_bars #(
    .NUM_BARS(NB), .BAR_HALF_W(HW), .MID_Y(MID),
    .HACTIVE(HA), .HFRONT_PORCH(HF), .HSYNC(HSY), .HBACK_PORCH(HB),
    .VACTIVE(VA), .VFRONT_PORCH(VF), .VSYNC(VSY), .VBACK_PORCH(VB)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raster position of the current cycle plus the programmer-visible state.
  int          m_h = 0, m_v = 0, m_fc = 0;
  bit          m_en, m_pend;
  logic [23:0] m_bg;
  int          sh_x[NB], sh_y[NB], ac_x[NB], ac_y[NB];
  logic [23:0] sh_c[NB], ac_c[NB];

  logic [27:0] pix_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fc = 0; m_en = 1'b1; m_pend = 1'b0;
    m_bg = {8'd10, 8'd20, 8'd30};
    for (int i = 0; i < NB; i++) begin
      sh_x[i] = (64 + 128 * i) % 640; ac_x[i] = sh_x[i];
      sh_y[i] = MID;                  ac_y[i] = MID;
      sh_c[i] = 24'h800080;           ac_c[i] = 24'h800080;
    end
  endtask

  task automatic model_write(input int a, input logic [31:0] d);
    int i, f;
    if (a == 0) m_bg = d[23:0];
    else if (a == 1) m_en = d[0];
    else if (a >= 8 && (a - 8) / 4 < NB) begin
      i = (a - 8) / 4;
      f = (a - 8) % 4;
      if (f == 0) sh_x[i] = int'(d[9:0]);
      if (f == 1) sh_y[i] = int'(d[9:0]);
      if (f == 2) sh_c[i] = d[23:0];
      if (f != 3) m_pend = 1'b1;
    end
  endtask

  function automatic logic [27:0] exp_pix();
    logic [23:0] col;
    bit vis, found, hs, vs;
    int xa, lo, hi;
    vis = (m_h < HA) && (m_v < VA);
    hs  = !(m_h >= HA + HF && m_h < HA + HF + HSY);
    vs  = !(m_v >= VA + VF && m_v < VA + VF + VSY);
    col = m_bg;
    found = 1'b0;
    if (m_en) begin
      for (int i = 0; i < NB; i++) begin
        xa = 2 * ac_x[i];
        lo = (ac_y[i] < MID) ? ac_y[i] : MID;
        hi = (ac_y[i] > MID) ? ac_y[i] : MID;
        if (!found && (xa - HW < m_h) && (m_h < xa + HW) && lo <= m_v && m_v <= hi) begin
          col = ac_c[i];
          found = 1'b1;
        end
      end
    end
    if (!vis) col = '0;
    return {col, hs, vs, vis, 1'(m_h % 2)};
  endfunction

  // Model: predict this cycle's output, then apply commit and bus writes seen this cycle.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      model_reset();
      pix_q.delete();
      rd_q.delete();
    end else begin
      pix_q.push_back(exp_pix());
      if (chipselect && read)
        rd_q.push_back((address == 16'd2) ? {m_pend, 15'd0, 16'(m_fc)} : 32'd0);
      if (m_h == 0 && m_v == VA) begin
        for (int i = 0; i < NB; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_c[i] = sh_c[i];
        end
        m_fc = (m_fc + 1) % 65536;
        m_pend = 1'b0;
      end
      if (chipselect && write) model_write(int'(address), writedata);
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
  end

  // Monitor: outputs emerge two cycles after the raster position that produced them.
  initial begin
    logic [27:0] e_pix;
    logic [31:0] e_rd;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (pix_q.size() >= 2) begin
          e_pix = pix_q.pop_front();
          check("pixel", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK}, e_pix);
        end
        if (rd_q.size() > 0) begin
          e_rd = rd_q.pop_front();
          check("readdata", readdata, e_rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = 16'(a); writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int a);
    chipselect = 1'b1; read = 1'b1; address = 16'(a);
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wait_until(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n <= 2 * FRAME) begin
      tick();
      n++;
    end
    check("wait_raster_pos", 32'(m_h == h && m_v == v), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int a, hs_lo, vs_lo, de_hi;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK},
          {24'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("reset_readdata", readdata, 32'd0);
    check("sync_n", 32'(VGA_SYNC_n), 32'd0);
    reset = 1'b0;

    wait_until(3, VA);
    bus_read(2);

    hs_lo = 0; vs_lo = 0; de_hi = 0;
    repeat (FRAME) begin
      @(posedge clk);
      #1;
      if (!VGA_HS) hs_lo++;
      if (!VGA_VS) vs_lo++;
      if (VGA_BLANK_n) de_hi++;
    end
    #1;
    check("hs_low_cycles", hs_lo, HSY * VT);
    check("vs_low_cycles", vs_lo, VSY * HT);
    check("blank_n_high_cycles", de_hi, HA * VA);

    // Bar 0 written mid-frame; bar 1 overlaps it on the centre row.
    wait_until(0, 3);
    bus_write(8, 32'd10);
    bus_write(9, 32'd2);
    bus_read(2);
    run_frames(2);
    bus_write(12, 32'd12);
    bus_write(13, 32'd11);
    bus_write(14, 32'h0000FF00);
    run_frames(2);

    // Bar 2 colour written exactly on the commit cycle.
    bus_write(16, 32'd40);
    bus_write(17, 32'd1);
    wait_until(0, VA);
    tick();
    wait_until(0, VA);
    bus_write(18, 32'h00123456);
    bus_read(2);
    run_frames(2);
    bus_read(2);

    // Left and right screen edges.
    bus_write(16, 32'd0);
    bus_write(20, 32'(HA / 2 - 1));
    bus_write(21, 32'd11);
    bus_write(22, 32'h000000FF);
    run_frames(2);

    bus_write(1, 32'd0);
    bus_write(0, $urandom);
    run_frames(1);
    bus_read(1);
    bus_write(1, 32'd1);

    repeat (150) begin
      repeat ($urandom_range(0, 60)) tick();
      a = $urandom_range(0, 8 + 4 * NB + 3);
      if ($urandom_range(0, 9) < 3) begin
        bus_read(a);
      end else begin
        d = $urandom;
        if (a == 1) d[0] = ($urandom_range(0, 3) != 0);
        else if (a >= 8 && (a - 8) % 4 == 0) d = $urandom_range(0, 90);
        else if (a >= 8 && (a - 8) % 4 == 1) d = $urandom_range(0, VT);
        bus_write(a, d);
      end
    end
    run_frames(1);
    bus_read(2);

    // Asynchronous reset mid-frame.
    wait_until(50, 4);
    reset = 1'b1;
    #1;
    check("midframe_reset_outputs", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK},
          {24'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("midframe_reset_readdata", readdata, 32'd0);
    tick();
    reset = 1'b0;
    wait_until(3, VA + 1);
    bus_read(2);
    run_frames(1);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_bars.md
# vga_bars

Parametrised multi-bar VGA renderer, the successor to the single-bar Avalon VGA peripheral. It renders NUM_BARS independently positioned and coloured vertical bars over a programmable background colour. Each bar extends from a configurable centre row to a per-bar endpoint. Bar registers are double-buffered: host writes land in shadow copies and are committed atomically at the start of vertical blanking, so bars never tear. The block sits on the Avalon-MM bus as a slave and drives the board VGA DAC directly.

## Interface
Parameters:
- NUM_BARS, 4: number of bars, 1..16.
- BAR_HALF_W, 8: bar half-width in hcount units (2 per pixel).
- MID_Y, 239: centre row that bars grow from.
- HACTIVE/HFRONT_PORCH/HSYNC/HBACK_PORCH, 1280/32/192/96: horizontal timing in 50 MHz cycles.
- VACTIVE/VFRONT_PORCH/VSYNC/VBACK_PORCH, 480/10/2/33: vertical timing in lines.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- chipselect, write, read  in  1 each  Avalon-MM slave strobes.
- address  in  16  word address.
- writedata  in  32  write data.
- readdata  out  32  read data, valid 1 cycle after read.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  VGA control; VGA_SYNC_n tied 0.

## Operation
- Internal counters: hcount (11 b) wraps at HTOTAL-1; vcount (10 b) increments on hcount wrap and wraps at VTOTAL-1. HS is low for hcount in [HACTIVE+HFRONT_PORCH, +HSYNC). VS is low for vcount in [VACTIVE+VFRONT_PORCH, +VSYNC). BLANK_n is high iff hcount<HACTIVE and vcount<VACTIVE. VGA_CLK = hcount[0].
- Address map (write):
  - 0: background {R,G,B} = writedata[23:16], [15:8], [7:0].
  - 1: control bit0 = display enable. When 0, the active area shows background only.
  - 8+4i (i<NUM_BARS): bar i x pixel column, writedata[9:0]. Stored as x<<1 in hcount units.
  - 9+4i: bar i y row, writedata[9:0].
  - 10+4i: bar i colour {R,G,B}.
  - Writes to other addresses are ignored.
- Background and control take effect immediately. Bar writes go to shadow registers and set pending=1.
- Commit point: the cycle with hcount==0 and vcount==VACTIVE. At that cycle:
  - all shadow bar registers are copied to the active registers;
  - pending clears;
  - frame_count (16 b) increments, wrapping 65535->0.
- Write and commit in the same cycle: the active registers receive the pre-write shadow value; the write lands in shadow; pending stays 1.
- Read map: address 2 returns {pending, 15'b0, frame_count}. Every other address returns 0.
- Pixel rule per bar, using active registers:
  - Column hit: xa-BAR_HALF_W < hcount < xa+BAR_HALF_W, computed in 12-bit signed arithmetic with no wrap. A bar at x=0 covers only hcount 0..7.
  - Row hit when y<MID_Y: y<=vcount<=MID_Y. When y>MID_Y: MID_Y<=vcount<=y. When y==MID_Y: only row MID_Y.
  - Overlaps: the lowest bar index wins. No hit gives the background colour. Blanking forces RGB=0.
- Reset values:
  - background {10,20,30}; enable=1; pending=0; frame_count=0; readdata=0.
  - bar i shadow and active: x=64+128i (mod 640), y=MID_Y, colour {80,00,80}.
  - counters=0; VGA_R/G/B=0; VGA_HS=1; VGA_VS=1; VGA_BLANK_n=0; VGA_CLK=0.

## Timing
- Pixel pipeline is 2 clk stages: stage 1 registers the hit vector, stage 2 selects and registers the colour.
- HS, VS, BLANK_n and VGA_CLK pass through 2 matching registers, so all VGA outputs stay aligned (latency 2 clk = 1 pixel).
- Immediate register write to visible effect: 3 clk.
- Bar write to visible effect: the first active line after the next commit point.
- Reset asserted mid-frame: all state returns to reset values asynchronously. The first commit occurs at vcount==VACTIVE of the first frame after release.

## Test plan
- Reset, then run 1 frame: HS low 192 cycles per line, VS low 2 lines per frame, BLANK_n high 1280×480 cycles per frame; frame_count reads 1 after the first commit.
- Bar 0 x=100, y=100 written mid-frame: the current frame is unchanged. Next frame: colour {80,00,80} for vcount 100..239 and hcount 193..207, background elsewhere.
- Bar 1 y=400, colour 0x00FF00: green for rows 239..400. At row 239 the overlap with bar 0 shows bar 0's colour.
- Write bar 2 colour exactly at hcount==0, vcount==480: the old shadow is committed, pending reads 1, and the new colour appears one frame later.
- Bar x=0 and x=639: no wrap. Coverage is only hcount 0..7 and 1271..1279 respectively.
- Enable=0: the active area shows background only. Read address 2 with frame_count forced past 65535: it wraps to 0.
